// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial MSB-first unsigned magnitude compare with early exit
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             abit, bbit;
    assign abit = a_q[idx];
    assign bbit = b_q[idx];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            greater <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    idx     <= IW'(WIDTH - 1);
                    greater <= 1'b0;
                    lesser  <= 1'b0;
                    equal   <= 1'b0;
                    busy    <= 1'b1;
                    state   <= COMPARE;
                end
                COMPARE: if (abit != bbit || idx == '0) begin
                    greater <= abit & ~bbit;
                    lesser  <= ~abit & bbit;
                    equal   <= abit == bbit;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end else begin
                    idx <= idx - IW'(1);
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
